exe_collect: RTL and testbench

- Writeback collector directly downstream of the functional units (alu, mul, div, lsu).
- Each cycle it scans every unit's `resp` slots, grants up to `cwd` valid results, and drives the matching `claim` bits back to the producers.
- Granted bundles are registered into a `cwd`-wide writeback bundle for the register file / ROB commit stage.
- Rotating unit priority guarantees that a non-pipelined unit holding a result (div) is never starved.

---
 rtl/exe_collect_pkg.sv | 20 ++
 rtl/exe_collect_rot_grant.sv | 85 ++++++++
 rtl/exe_collect.sv | 100 ++++++++++
 tb/tb_exe_collect.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exe_collect_pkg.sv
// Shared types for the writeback collector: the functional-unit result bundle
// and the index of the opid bit that marks a bundle as valid.
package exe_collect_pkg;

  localparam int OPID_VLD = 15;

  typedef struct packed {
    logic [15:0] opid;
    logic [5:0]  rd;
    logic [31:0] data;
  } exe_bundle_t;

  // Modular add for operands already below m; avoids a general divider.
  function automatic int wrap_add(input int a, input int b, input int m);
    int sum;
    sum = a + b;
    return (sum >= m) ? sum - m : sum;
  endfunction

endpackage

// File: rtl/exe_collect_rot_grant.sv
// Rotating-priority grant scan: visits units from rr_ptr onward, grants a valid
// prefix of each unit's slots until the writeback limit is reached.
module rot_grant
  import exe_collect_pkg::*;
#(
  parameter  int nfu = 4,
  parameter  int ewd = 4,
  parameter  int cwd = 4,
  localparam int PW  = (nfu > 1) ? $clog2(nfu) : 1,
  localparam int SW  = (ewd > 1) ? $clog2(ewd) : 1,
  localparam int CW  = $clog2(cwd + 1)
) (
  input  logic [nfu-1:0][ewd-1:0] valid,
  input  logic [PW-1:0]           rr_ptr,
  input  logic [CW-1:0]           limit,
  output logic [nfu-1:0][ewd-1:0] grant,
  output logic [cwd-1:0][PW-1:0]  g_unit,
  output logic [cwd-1:0][SW-1:0]  g_slot,
  output logic [CW-1:0]           n,
  output logic [PW-1:0]           rr_ptr_nxt
);

  int             cnt;
  int             last;
  int             unit_f;
  logic           open;
  logic           last_left;
  logic [ewd-1:0] row;
  logic [ewd-1:0] row_g;

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    grant      = '0;
    g_unit     = '0;
    g_slot     = '0;
    n          = '0;
    rr_ptr_nxt = rr_ptr;
    cnt        = 0;
    last       = 0;
    unit_f     = 0;
    open       = 1'b0;
    last_left  = 1'b0;
    row        = '0;
    row_g      = '0;

    for (int i = 0; i < nfu; i++) begin
      unit_f = wrap_add(int'(rr_ptr), i, nfu);
      row    = '0;
      row_g  = '0;
      open   = 1'b1;
      for (int j = 0; j < nfu; j++) begin
        if (j == unit_f) row = valid[j];
      end
      // First invalid slot (or exhausted budget) closes this unit's scan.
      for (int s = 0; s < ewd; s++) begin
        if (open && row[s] && (cnt < int'(limit))) begin
          row_g[s] = 1'b1;
          for (int k = 0; k < cwd; k++) begin
            if (k == cnt) begin
              g_unit[k] = PW'(unit_f);
              g_slot[k] = SW'(s);
            end
          end
          cnt = cnt + 1;
        end else begin
          open = 1'b0;
        end
      end
      if (row_g != '0) begin
        last      = unit_f;
        last_left = |(row & ~row_g);
      end
      for (int j = 0; j < nfu; j++) begin
        if (j == unit_f) grant[j] = row_g;
      end
    end

    n = CW'(cnt);
    // Stay on a unit that still holds results so a slow unit keeps its turn.
    if (cnt != 0) begin
      rr_ptr_nxt = last_left ? PW'(last) : PW'(wrap_add(last, 1, nfu));
    end
  end

endmodule

// File: rtl/exe_collect.sv
// Writeback collector: claims up to cwd results per cycle from the functional
// units and registers them, packed low, into the writeback bundle.
module exe_collect
  import exe_collect_pkg::*;
#(
  parameter int nfu = 4,
  parameter int ewd = 4,
  parameter int cwd = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  exe_bundle_t [nfu-1:0][ewd-1:0]    resp,
  output logic        [nfu-1:0][ewd-1:0]    claim,
  input  logic                              wb_ready,
  output exe_bundle_t [cwd-1:0]             wb
);

  localparam int PW = (nfu > 1) ? $clog2(nfu) : 1;
  localparam int SW = (ewd > 1) ? $clog2(ewd) : 1;
  localparam int CW = $clog2(cwd + 1);

  exe_bundle_t [cwd-1:0]          wb_q, wb_d;
  logic [PW-1:0]                  rr_ptr_q, rr_ptr_d;
  logic [nfu-1:0][ewd-1:0]        valid;
  logic [nfu-1:0][ewd-1:0]        grant;
  logic [cwd-1:0][PW-1:0]         g_unit;
  logic [cwd-1:0][SW-1:0]         g_slot;
  logic [CW-1:0]                  g_n;
  logic [PW-1:0]                  rr_ptr_nxt;
  logic                           wb_any;
  logic                           acc;

  always_comb begin
    valid  = '0;
    wb_any = 1'b0;
    for (int f = 0; f < nfu; f++) begin
      for (int s = 0; s < ewd; s++) begin
        valid[f][s] = resp[f][s].opid[OPID_VLD];
      end
    end
    for (int k = 0; k < cwd; k++) begin
      wb_any = wb_any | wb_q[k].opid[OPID_VLD];
    end
  end

  // Accept only when the writeback register is free or drains this cycle.
  assign acc = rst & ~flush & (wb_ready | ~wb_any);

  rot_grant #(
    .nfu (nfu),
    .ewd (ewd),
    .cwd (cwd)
  ) u_rot_grant (
    .valid      (valid),
    .rr_ptr     (rr_ptr_q),
    .limit      (CW'(cwd)),
    .grant      (grant),
    .g_unit     (g_unit),
    .g_slot     (g_slot),
    .n          (g_n),
    .rr_ptr_nxt (rr_ptr_nxt)
  );

  always_comb begin
    claim    = '0;
    wb_d     = wb_q;
    rr_ptr_d = rr_ptr_q;
    if (acc) begin
      claim    = grant;
      rr_ptr_d = rr_ptr_nxt;
      wb_d     = '0;
      for (int k = 0; k < cwd; k++) begin
        if (CW'(k) < g_n) begin
          for (int f = 0; f < nfu; f++) begin
            for (int s = 0; s < ewd; s++) begin
              if ((g_unit[k] == PW'(f)) && (g_slot[k] == SW'(s))) wb_d[k] = resp[f][s];
            end
          end
        end
      end
    end else if (flush) begin
      wb_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst) begin
      wb_q     <= '0;
      rr_ptr_q <= '0;
    end else begin
      wb_q     <= wb_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign wb = wb_q;

endmodule

// File: tb/tb_exe_collect.sv
// Self-checking bench for exe_collect: queue-based scan model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_exe_collect;
  import exe_collect_pkg::*;

  localparam int NFU = 4;
  localparam int EWD = 4;
  localparam int CWD = 4;

  logic                           clk;
  logic                           rst;
  logic                           flush;
  logic                           wb_ready;
  exe_bundle_t [NFU-1:0][EWD-1:0] resp;
  logic [NFU-1:0][EWD-1:0]        claim;
  exe_bundle_t [CWD-1:0]          wb;

  exe_collect #(.nfu(NFU), .ewd(EWD), .cwd(CWD)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .resp     (resp),
    .claim    (claim),
    .wb_ready (wb_ready),
    .wb       (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model state: registered writeback contents and rotating pointer.
  exe_bundle_t [CWD-1:0]   m_wb        = '0;
  int                      m_rr        = 0;
  exe_bundle_t [CWD-1:0]   exp_wb_next = '0;
  int                      exp_rr_next = 0;
  logic [NFU-1:0][EWD-1:0] exp_claim   = '0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exe_bundle_t mk(input logic [15:0] opid);
    exe_bundle_t b;
    b.opid = opid;
    b.rd   = opid[5:0];
    b.data = 32'hA000_0000 | {16'h0, opid};
    return b;
  endfunction

  // Candidate list in rotating order, each unit contributing its valid prefix;
  // the first CWD candidates win.
  task automatic model_eval();
    int   cand[$];
    int   ntake;
    int   last;
    int   u;
    logic any_wb;
    logic accept;
    logic left;
    exp_claim   = '0;
    exp_wb_next = m_wb;
    exp_rr_next = m_rr;
    if (!rst) begin
      exp_wb_next = '0;
      exp_rr_next = 0;
      return;
    end
    any_wb = 1'b0;
    for (int k = 0; k < CWD; k++) any_wb = any_wb | m_wb[k].opid[15];
    accept = !flush && (wb_ready || !any_wb);
    if (!accept) begin
      if (flush) exp_wb_next = '0;
      return;
    end
    for (int i = 0; i < NFU; i++) begin
      u = (m_rr + i) % NFU;
      for (int s = 0; s < EWD; s++) begin
        if (!resp[u][s].opid[15]) break;
        cand.push_back(u * EWD + s);
      end
    end
    ntake       = (cand.size() < CWD) ? cand.size() : CWD;
    exp_wb_next = '0;
    for (int k = 0; k < ntake; k++) begin
      exp_wb_next[k] = resp[cand[k] / EWD][cand[k] % EWD];
      exp_claim[cand[k] / EWD][cand[k] % EWD] = 1'b1;
    end
    if (ntake > 0) begin
      last = cand[ntake-1] / EWD;
      left = 1'b0;
      for (int s = 0; s < EWD; s++) begin
        if (resp[last][s].opid[15] && !exp_claim[last][s]) left = 1'b1;
      end
      exp_rr_next = left ? last : (last + 1) % NFU;
    end
  endtask

  always @(negedge clk) begin
    model_eval();
    check("claim", claim, exp_claim);
    check("wb", wb, m_wb);
  end

  always @(posedge clk) begin
    m_wb <= exp_wb_next;
    m_rr <= exp_rr_next;
  end

  // Advance one edge; producers retire whatever was claimed in that cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int f = 0; f < NFU; f++)
      for (int s = 0; s < EWD; s++)
        if (exp_claim[f][s]) resp[f][s] = '0;
  endtask

  initial begin
    rst      = 1'b0;
    flush    = 1'b0;
    wb_ready = 1'b1;
    resp     = '0;
    tick();
    tick();
    check("reset_wb", wb, 0);
    check("reset_claim", claim, 0);
    check("reset_rr", m_rr, 0);
    rst = 1'b1;
    tick();

    // Single result from unit 2.
    resp[2][0] = mk(16'h8005);
    #1 check("single_claim", claim, 16'h0100);
    tick();
    check("single_wb0", wb[0].opid, 16'h8005);
    check("single_wb_hi", wb[3:1], 0);
    check("single_rr", m_rr, 3);

    // Bring pointer back to 0 via unit 3, then overflow with 8 results.
    resp[3][0] = mk(16'h8006);
    tick();
    check("ovf_rr0", m_rr, 0);
    for (int u = 0; u < NFU; u++)
      for (int s = 0; s < 2; s++) resp[u][s] = mk(16'h8100 + 16'(u * 16 + s));
    #1 check("ovf_claim_a", claim, 16'h0033);
    tick();
    check("ovf_wb_a", {wb[3].opid, wb[2].opid, wb[1].opid, wb[0].opid}, 64'h8111_8110_8101_8100);
    check("ovf_rr_a", m_rr, 2);
    #1 check("ovf_claim_b", claim, 16'h3300);
    tick();
    check("ovf_wb_b", {wb[3].opid, wb[2].opid, wb[1].opid, wb[0].opid}, 64'h8131_8130_8121_8120);
    check("ovf_rr_b", m_rr, 0);

    // Prefix rule: slot 1 behind an invalid slot 0 is never claimed.
    resp       = '0;
    resp[1][1] = mk(16'h8040);
    repeat (3) begin
      #1 check("prefix_claim", claim, 0);
      tick();
    end
    check("prefix_wb", wb, 0);
    resp = '0;

    // Stall with wb held, then release.
    resp[0][0] = mk(16'h8011);
    tick();
    wb_ready   = 1'b0;
    resp[1][0] = mk(16'h8012);
    resp[1][1] = mk(16'h8013);
    repeat (3) begin
      #1 check("stall_claim", claim, 0);
      check("stall_wb0", wb[0].opid, 16'h8011);
      tick();
    end
    wb_ready = 1'b1;
    #1 check("release_claim", claim, 16'h0030);
    tick();
    check("release_wb", {wb[1].opid, wb[0].opid}, 32'h8013_8012);
    check("release_rr", m_rr, 2);

    // Starvation: div on unit 3 competes with a saturating unit 0.
    resp[2][0] = mk(16'h8050);
    resp[3][0] = mk(16'h8051);
    tick();
    check("starve_rr0", m_rr, 0);
    resp[3][0] = mk(16'h8020);
    for (int s = 0; s < EWD; s++) resp[0][s] = mk(16'h8200 + 16'(s));
    #1 check("starve_claim_a", claim, 16'h000F);
    tick();
    for (int s = 0; s < EWD; s++) resp[0][s] = mk(16'h8204 + 16'(s));
    #1 check("starve_claim_b", claim, 16'h1007);
    tick();
    check("starve_wb", {wb[1].opid, wb[0].opid}, 32'h8204_8020);
    check("starve_rr", m_rr, 0);

    // Flush while wb holds two results and three slots are valid.
    resp       = '0;
    resp[1][0] = mk(16'h8070);
    resp[1][1] = mk(16'h8071);
    tick();
    check("flush_pre_wb", {wb[2].opid, wb[1].opid, wb[0].opid}, 48'h0000_8071_8070);
    check("flush_pre_rr", m_rr, 2);
    flush      = 1'b1;
    resp[1][0] = mk(16'h8080);
    resp[2][0] = mk(16'h8081);
    resp[2][1] = mk(16'h8082);
    #1 check("flush_claim", claim, 0);
    tick();
    flush = 1'b0;
    check("flush_wb", wb, 0);
    check("flush_rr", m_rr, 2);

    // Reset in the middle of a stall.
    wb_ready = 1'b0;
    #1 check("rstall_claim", claim, 16'h0310);
    tick();
    check("rstall_wb", {wb[2].opid, wb[1].opid, wb[0].opid}, 48'h8080_8082_8081);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rstall_wb_clr", wb, 0);
    check("rstall_rr", m_rr, 0);
    wb_ready   = 1'b1;
    resp       = '0;
    resp[3][0] = mk(16'h8060);
    resp[0][0] = mk(16'h8061);
    #1 check("post_rst_claim", claim, 16'h1001);
    tick();
    check("post_rst_wb", {wb[1].opid, wb[0].opid}, 32'h8060_8061);

    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
